// File: rtl/ifu_trace_ring.sv
// Instruction-trace ring buffer on the IFU fetch stream: captures fetches while armed,
// freezes POST_TRIG fetches after a trigger instruction, then drains oldest-first.
module ifu_trace_ring #(
    parameter int                ADDR_W    = 32,
    parameter int                INST_W    = 32,
    parameter int                DEPTH     = 16,
    parameter int                POST_TRIG = 4,
    parameter logic [INST_W-1:0] TRIG_INST = 32'h00100073
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [INST_W-1:0]        out_inst,
    output logic                     out_last,
    output logic                     trig_hit,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [PTR_W-1:0] POST_LAST = PTR_W'(POST_TRIG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_POST,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_post_cnt;
    logic               r_trig_hit;
    logic [ADDR_W-1:0]  r_ring_addr [DEPTH];
    logic [INST_W-1:0]  r_ring_inst [DEPTH];

    logic               w_write;
    logic               w_is_trig;
    logic               w_out_valid;
    logic               w_pop;
    logic [PTR_W-1:0]   w_post_nxt;
    logic               w_post_done;

    assign w_write     = in_valid && ((r_state == S_CAPTURE) || (r_state == S_POST));
    assign w_is_trig   = (in_inst == TRIG_INST);
    assign w_out_valid = (r_state == S_DRAIN) && (r_count != '0);
    assign w_pop       = w_out_valid && out_ready;
    assign w_post_nxt  = r_post_cnt + 1'b1;
    assign w_post_done = (w_post_nxt == POST_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (arm) w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (in_valid && w_is_trig)
                           w_state_nxt = (POST_TRIG == 0) ? S_DRAIN : S_POST;
            S_POST:    if (in_valid && w_post_done) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_pop && (r_count == ONE)) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_trig_hit <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && arm) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_trig_hit <= 1'b0;
            end else if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                // A full ring drops its oldest entry so the window slides with the writes.
                if (r_count == FULL) r_rd_ptr <= r_rd_ptr + 1'b1;
                else                 r_count  <= r_count + 1'b1;
                if (w_is_trig) r_trig_hit <= 1'b1;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end

            // Only the first trigger starts the post window; later matches are just data.
            if ((r_state == S_CAPTURE) && in_valid && w_is_trig)
                r_post_cnt <= '0;
            else if ((r_state == S_POST) && in_valid)
                r_post_cnt <= w_post_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && w_write) begin
            r_ring_addr[r_wr_ptr] <= in_addr;
            r_ring_inst[r_wr_ptr] <= in_inst;
        end
    end

    assign out_valid = w_out_valid;
    assign out_addr  = r_ring_addr[r_rd_ptr];
    assign out_inst  = r_ring_inst[r_rd_ptr];
    assign out_last  = w_out_valid && (r_count == ONE);
    assign trig_hit  = r_trig_hit;
    assign busy      = (r_state != S_IDLE);
    assign count     = r_count;
endmodule

// File: tb/tb_ifu_trace_ring.sv
// Directed bench for ifu_trace_ring: capture, wrap, back-pressure, trigger edge cases, reset.
module tb_ifu_trace_ring;
    localparam logic [31:0] TRIG = 32'h00100073;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_inst = '0;
    logic        out_ready = 1'b0;

    logic        out_valid, out_last, trig_hit, busy;
    logic [31:0] out_addr, out_inst;
    logic [4:0]  count;

    logic        d0_out_valid, d0_out_last, d0_trig_hit, d0_busy;
    logic [31:0] d0_out_addr, d0_out_inst;
    logic [4:0]  d0_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ifu_trace_ring #(.ADDR_W(32), .INST_W(32), .DEPTH(16), .POST_TRIG(4), .TRIG_INST(TRIG)) dut (
        .clock(clock), .reset(reset), .arm(arm), .in_valid(in_valid),
        .in_addr(in_addr), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_inst(out_inst), .out_last(out_last),
        .trig_hit(trig_hit), .busy(busy), .count(count)
    );

    ifu_trace_ring #(.ADDR_W(32), .INST_W(32), .DEPTH(16), .POST_TRIG(0), .TRIG_INST(TRIG)) dut0 (
        .clock(clock), .reset(reset), .arm(arm), .in_valid(in_valid),
        .in_addr(in_addr), .in_inst(in_inst), .out_valid(d0_out_valid), .out_ready(out_ready),
        .out_addr(d0_out_addr), .out_inst(d0_out_inst), .out_last(d0_out_last),
        .trig_hit(d0_trig_hit), .busy(d0_busy), .count(d0_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] i);
        in_valid = 1'b1;
        in_addr  = a;
        in_inst  = i;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run7(input logic [31:0] base);
        for (int k = 0; k < 7; k++)
            fetch(base + 32'(4 * k), (k == 2) ? TRIG : NOP);
    endtask

    task automatic drain_check(input string tag, input logic [31:0] base, input int n, input int trig_idx);
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_valid"}, 64'(out_valid), 64'(1));
            chk({tag, "_addr"}, 64'(out_addr), 64'(base + 32'(4 * k)));
            chk({tag, "_inst"}, 64'(out_inst), 64'((k == trig_idx) ? TRIG : NOP));
            chk({tag, "_last"}, 64'(out_last), 64'(k == n - 1));
            tick();
        end
        out_ready = 1'b0;
        chk({tag, "_idle"}, 64'(busy), 64'(0));
        chk({tag, "_empty"}, 64'(count), 64'(0));
        chk({tag, "_novalid"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        // reset dominates arm and in_valid
        reset = 1'b0; arm = 1'b1; in_valid = 1'b1; in_inst = TRIG;
        repeat (3) tick();
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_trig", 64'(trig_hit), 64'(0));
        reset = 1'b1; arm = 1'b0; in_valid = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'(0));

        // short run: 3 to trigger, 4 post
        do_arm();
        chk("arm_busy", 64'(busy), 64'(1));
        chk("arm_count", 64'(count), 64'(0));
        for (int k = 0; k < 3; k++)
            fetch(32'h80000000 + 32'(4 * k), (k == 2) ? TRIG : NOP);
        chk("short_trig", 64'(trig_hit), 64'(1));
        chk("short_cnt3", 64'(count), 64'(3));
        chk("short_post_novalid", 64'(out_valid), 64'(0));
        for (int k = 3; k < 7; k++)
            fetch(32'h80000000 + 32'(4 * k), NOP);
        chk("short_cnt7", 64'(count), 64'(7));
        chk("short_drain_valid", 64'(out_valid), 64'(1));
        fetch(32'hDEAD0000, NOP);
        chk("short_drop_in_drain", 64'(count), 64'(7));
        drain_check("short", 32'h80000000, 7, 2);
        chk("short_trig_sticky", 64'(trig_hit), 64'(1));

        // wrap: 40 fetches, trigger at 35
        do_arm();
        chk("wrap_trig_clr", 64'(trig_hit), 64'(0));
        for (int k = 0; k < 40; k++)
            fetch(32'h1000 + 32'(4 * k), (k == 35) ? TRIG : NOP);
        chk("wrap_count", 64'(count), 64'(16));
        drain_check("wrap", 32'h1000 + 32'(4 * 24), 16, 11);

        // back-pressure: out_ready toggles each cycle
        do_arm();
        run7(32'h2000);
        begin
            int idx = 0;
            for (int cyc = 0; cyc < 40 && idx < 7; cyc++) begin
                out_ready = (cyc % 2 == 0);
                #1;
                chk("bp_valid", 64'(out_valid), 64'(1));
                chk("bp_addr", 64'(out_addr), 64'(32'h2000 + 32'(4 * idx)));
                chk("bp_last", 64'(out_last), 64'(idx == 6));
                if (out_ready) idx++;
                tick();
            end
            out_ready = 1'b0;
            chk("bp_all_drained", 64'(idx), 64'(7));
            chk("bp_idle", 64'(busy), 64'(0));
        end

        // arm ignored mid-capture; second trigger does not restart the post window
        do_arm();
        fetch(32'h6000, NOP);
        fetch(32'h6004, NOP);
        do_arm();
        chk("rearm_ignored_cnt", 64'(count), 64'(2));
        chk("rearm_ignored_busy", 64'(busy), 64'(1));
        fetch(32'h6008, TRIG);
        fetch(32'h600C, NOP);
        fetch(32'h6010, TRIG);
        fetch(32'h6014, NOP);
        chk("post2_not_yet", 64'(out_valid), 64'(0));
        fetch(32'h6018, NOP);
        chk("post2_drain", 64'(out_valid), 64'(1));
        chk("post2_count", 64'(count), 64'(7));
        reset = 1'b0; tick(); reset = 1'b1;

        // POST_TRIG=0 build drains on the trigger edge
        do_arm();
        fetch(32'h5000, NOP);
        fetch(32'h5004, NOP);
        fetch(32'h5008, TRIG);
        chk("pt0_valid", 64'(d0_out_valid), 64'(1));
        chk("pt0_count", 64'(d0_count), 64'(3));
        chk("pt0_addr", 64'(d0_out_addr), 64'(32'h5000));
        chk("pt0_trig", 64'(d0_trig_hit), 64'(1));
        chk("pt4_still_post", 64'(out_valid), 64'(0));
        reset = 1'b0; tick(); reset = 1'b1;

        // reset mid-drain, then clean re-arm
        do_arm();
        run7(32'h4000);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        chk("mid_count", 64'(count), 64'(5));
        chk("mid_addr", 64'(out_addr), 64'(32'h4008));
        reset = 1'b0; out_ready = 1'b1;
        tick();
        reset = 1'b1; out_ready = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_count", 64'(count), 64'(0));
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        do_arm();
        for (int k = 0; k < 5; k++)
            fetch(32'h3000 + 32'(4 * k), (k == 0) ? TRIG : NOP);
        chk("rearm_count", 64'(count), 64'(5));
        drain_check("rearm", 32'h3000, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
